car_sequence_detector: RTL and testbench
========================================

CAR_SEQUENCE_DETECTOR -- requirements
Module: car_sequence_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive sync'd cycles a sensor must hold a new level before it is accepted; legal range 1..255.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizer; legal range 2..3.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 sensor_a  input  1  raw outer photo-sensor, asynchronous, 1 = beam blocked.
REQ-006 sensor_b  input  1  raw inner photo-sensor, asynchronous, 1 = beam blocked.
REQ-007 car_enter  output  1  one-cycle pulse when a complete entry sequence finishes.
REQ-008 car_exit  output  1  one-cycle pulse when a complete exit sequence finishes.
REQ-009 cnt_en  output  1  equals car_enter OR car_exit; drives the occupancy counter enable.
REQ-010 cnt_up  output  1  equals car_enter; drives the occupancy counter direction (1 = increment).
REQ-011 seq_error  output  1  one-cycle pulse on entry into the ERR state.
REQ-012 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-013 Each sensor SHALL pass through a SYNC_STAGES-deep synchronizer before any other logic.
REQ-014 Debounce: the filtered level fa/fb SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate return to the filtered level SHALL clear the hold count.
REQ-015 Latency from raw edge to filtered edge SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles, with no more than 1 cycle of uncertainty.
REQ-016 FSM states: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, ERR. The FSM is evaluated on {fa,fb} each cycle.
REQ-017 Entry path: IDLE -{10}-> EN_A -{11}-> EN_AB -{01}-> EN_B -{00}-> IDLE, asserting car_enter in the cycle after the 00 is sampled.
REQ-018 Exit path: IDLE -{01}-> EX_B -{11}-> EX_AB -{10}-> EX_A -{00}-> IDLE, asserting car_exit in the cycle after the 00 is sampled.
REQ-019 Backing out: EN_A-{00} -> IDLE, EN_AB-{10} -> EN_A, EN_B-{11} -> EN_AB; EX_B-{00} -> IDLE, EX_AB-{01} -> EX_B, EX_A-{11} -> EX_AB. None of these transitions produces a pulse.
REQ-020 An unchanged input SHALL hold the current state.
REQ-021 Any other input in any non-ERR state SHALL be an illegal jump (e.g. IDLE-{11}, EN_A-{01}, EN_B-{10}); the FSM SHALL go to ERR and pulse seq_error once.
REQ-022 ERR SHALL hold until {fa,fb} = 00 is sampled, then return to IDLE without a pulse.
REQ-023 car_enter, car_exit and seq_error SHALL be registered and mutually exclusive; each SHALL be high for at most 1 cycle per event.
REQ-024 Back-to-back cars: a new 10 arriving in the cycle after a completed sequence returns to IDLE SHALL start a new sequence with no lost event.

Reset
REQ-025 While rst_n = 0 at a clk edge: FSM -> IDLE; synchronizers, fa and fb -> 0; debounce counts -> 0; all pulse outputs -> 0; state_o -> IDLE encoding.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no pulse; after release, the sensors SHALL be re-debounced from 0 before the FSM acts.

Structure
REQ-027 The state enum type (3 bits) and its default parameter values SHALL live in a shared package, car_fsm_pkg, which also holds the counter-facing constants.
REQ-028 One sub-module, sensor_debounce (synchronizer plus hold counter, one per sensor), SHALL be instantiated twice.
REQ-029 cnt_en and cnt_up SHALL connect directly to the occupancy up/down counter without extra glue logic.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Entry: raw ab = 10, 11, 01, 00, each held 10 cycles -> exactly one car_enter, cnt_en=1 and cnt_up=1 for 1 cycle, 6-7 cycles after the last edge; no other pulses.
REQ-031 Exit: raw ab = 01, 11, 10, 00 -> exactly one car_exit, with cnt_en=1 and cnt_up=0.
REQ-032 Glitch: sensor_a pulses high for 3 cycles, then low -> fa stays 0, state stays IDLE, no outputs.
REQ-033 Back-out: 10, 11, 10, 00 -> states EN_A, EN_AB, EN_A, IDLE; no pulses.
REQ-034 Illegal jump: IDLE then ab = 11 -> ERR and one seq_error; ab = 01 keeps ERR; ab = 00 returns to IDLE; then a full entry yields one car_enter.
REQ-035 Reset in EN_AB -> state IDLE, no pulse; with ab held at 11 after release, the FSM goes to ERR after the debounce delay.

Source files
------------

// File: rtl/car_fsm_pkg.sv
// Shared types and constants for the car entry/exit sequence detector:
// FSM state encoding, parameter defaults and counter-facing constants.
package car_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EN_A  = 3'd1,
        ST_EN_AB = 3'd2,
        ST_EN_B  = 3'd3,
        ST_EX_B  = 3'd4,
        ST_EX_AB = 3'd5,
        ST_EX_A  = 3'd6,
        ST_ERR   = 3'd7
    } car_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int SYNC_STAGES_DEF     = 2;

    // Hold counter is wide enough for the largest legal DEBOUNCE_CYCLES (255).
    localparam int HOLD_CNT_W = 8;

    // Sensor pair patterns as {fa, fb}.
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

    // Occupancy counter direction encoding.
    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronizer plus hold-count debounce for one asynchronous photo-sensor.
// The filtered level flips only after the synced level differs for DEBOUNCE_CYCLES cycles.
module sensor_debounce
    import car_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   filt_reg;
    logic                   filt_next;
    logic [HOLD_CNT_W-1:0]  hold_cnt_reg;
    logic [HOLD_CNT_W-1:0]  hold_cnt_next;
    logic                   sync_level;

    assign sync_level = sync_reg[SYNC_STAGES-1];
    assign filt       = filt_reg;

    always_comb begin
        filt_next     = filt_reg;
        hold_cnt_next = '0;
        // Any cycle where the synced level matches the filtered one clears the count.
        if (sync_level != filt_reg) begin
            if (hold_cnt_reg == HOLD_LAST) begin
                filt_next = sync_level;
            end else begin
                hold_cnt_next = hold_cnt_reg + HOLD_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            filt_reg     <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], raw};
            filt_reg     <= filt_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

endmodule

// File: rtl/car_sequence_detector.sv
// Two-sensor car entry/exit detector: debounced sensors drive a direction FSM
// whose registered pulses feed an occupancy up/down counter directly.
module car_sequence_detector
    import car_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic       car_enter,
    output logic       car_exit,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       seq_error,
    output logic [2:0] state_o
);

    logic [1:0] raw_ab;
    logic [1:0] filt_ab;

    car_state_t state_reg;
    car_state_t state_next;
    logic       car_enter_reg;
    logic       car_enter_next;
    logic       car_exit_reg;
    logic       car_exit_next;
    logic       seq_error_reg;
    logic       seq_error_next;
    logic       cnt_en_reg;
    logic       cnt_up_reg;

    assign raw_ab = {sensor_a, sensor_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            sensor_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_debounce (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw_ab[gi]),
                .filt (filt_ab[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        car_enter_next = 1'b0;
        car_exit_next  = 1'b0;
        // Each state lists its legal moves and its illegal jumps; the pattern
        // that defines the current state falls to default and holds.
        case (state_reg)
            ST_IDLE: begin
                case (filt_ab)
                    AB_A:    state_next = ST_EN_A;
                    AB_B:    state_next = ST_EX_B;
                    AB_BOTH: state_next = ST_ERR;
                    default: state_next = ST_IDLE;
                endcase
            end
            ST_EN_A: begin
                case (filt_ab)
                    AB_BOTH: state_next = ST_EN_AB;
                    AB_NONE: state_next = ST_IDLE;
                    AB_B:    state_next = ST_ERR;
                    default: state_next = ST_EN_A;
                endcase
            end
            ST_EN_AB: begin
                case (filt_ab)
                    AB_B:    state_next = ST_EN_B;
                    AB_A:    state_next = ST_EN_A;
                    AB_NONE: state_next = ST_ERR;
                    default: state_next = ST_EN_AB;
                endcase
            end
            ST_EN_B: begin
                case (filt_ab)
                    AB_NONE: begin
                        state_next     = ST_IDLE;
                        car_enter_next = 1'b1;
                    end
                    AB_BOTH: state_next = ST_EN_AB;
                    AB_A:    state_next = ST_ERR;
                    default: state_next = ST_EN_B;
                endcase
            end
            ST_EX_B: begin
                case (filt_ab)
                    AB_BOTH: state_next = ST_EX_AB;
                    AB_NONE: state_next = ST_IDLE;
                    AB_A:    state_next = ST_ERR;
                    default: state_next = ST_EX_B;
                endcase
            end
            ST_EX_AB: begin
                case (filt_ab)
                    AB_A:    state_next = ST_EX_A;
                    AB_B:    state_next = ST_EX_B;
                    AB_NONE: state_next = ST_ERR;
                    default: state_next = ST_EX_AB;
                endcase
            end
            ST_EX_A: begin
                case (filt_ab)
                    AB_NONE: begin
                        state_next    = ST_IDLE;
                        car_exit_next = 1'b1;
                    end
                    AB_BOTH: state_next = ST_EX_AB;
                    AB_B:    state_next = ST_ERR;
                    default: state_next = ST_EX_A;
                endcase
            end
            ST_ERR: begin
                if (filt_ab == AB_NONE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        seq_error_next = (state_next == ST_ERR) && (state_reg != ST_ERR);
    end

    // Counter controls are registered alongside the pulses so the counter sees plain flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            car_enter_reg <= 1'b0;
            car_exit_reg  <= 1'b0;
            seq_error_reg <= 1'b0;
            cnt_en_reg    <= 1'b0;
            cnt_up_reg    <= CNT_DIR_DOWN;
        end else begin
            state_reg     <= state_next;
            car_enter_reg <= car_enter_next;
            car_exit_reg  <= car_exit_next;
            seq_error_reg <= seq_error_next;
            cnt_en_reg    <= car_enter_next | car_exit_next;
            cnt_up_reg    <= car_enter_next ? CNT_DIR_UP : CNT_DIR_DOWN;
        end
    end

    assign car_enter = car_enter_reg;
    assign car_exit  = car_exit_reg;
    assign seq_error = seq_error_reg;
    assign cnt_en    = cnt_en_reg;
    assign cnt_up    = cnt_up_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_car_sequence_detector.sv
// Directed scenario bench for car_sequence_detector at DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_car_sequence_detector;
    import car_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_a = 1'b0;
    logic       sensor_b = 1'b0;
    logic       car_enter;
    logic       car_exit;
    logic       cnt_en;
    logic       cnt_up;
    logic       seq_error;
    logic [2:0] state_o;

    int total = 0;
    int bad = 0;
    int n_enter, n_exit, n_err, n_cnt_en, n_cnt_up, n_excl, n_glue, n_nonidle;
    int enter_at, exit_at;

    car_sequence_detector #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sensor_a (sensor_a),
        .sensor_b (sensor_b),
        .car_enter(car_enter),
        .car_exit (car_exit),
        .cnt_en   (cnt_en),
        .cnt_up   (cnt_up),
        .seq_error(seq_error),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        n_enter = 0; n_exit = 0; n_err = 0; n_cnt_en = 0; n_cnt_up = 0;
        n_excl = 0; n_glue = 0; n_nonidle = 0; enter_at = -1; exit_at = -1;
    endtask

    // Drive raw {a,b} and tally output activity for n cycles, sampled 1ns after each edge.
    task automatic hold(input logic a, input logic b, input int n);
        sensor_a = a;
        sensor_b = b;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (car_enter === 1'b1) begin n_enter++; enter_at = i; end
            if (car_exit === 1'b1) begin n_exit++; exit_at = i; end
            if (seq_error === 1'b1) n_err++;
            if (cnt_en === 1'b1) n_cnt_en++;
            if (cnt_up === 1'b1) n_cnt_up++;
            if (int'(car_enter) + int'(car_exit) + int'(seq_error) > 1) n_excl++;
            if (cnt_en !== (car_enter | car_exit) || cnt_up !== car_enter) n_glue++;
            if (state_o !== ST_IDLE) n_nonidle++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_counts();
        hold(1'b0, 1'b0, 3);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
        total++; if ({car_enter, car_exit, seq_error, cnt_en, cnt_up} !== 5'b0) begin bad++; $display("FAIL reset_outputs: got %b want 00000", {car_enter, car_exit, seq_error, cnt_en, cnt_up}); end
        rst_n = 1'b1;
        clear_counts();
        hold(1'b0, 1'b0, 8);
        total++; if (n_nonidle + n_enter + n_exit + n_err !== 0) begin bad++; $display("FAIL reset_quiet: got %0d events want 0", n_nonidle + n_enter + n_exit + n_err); end
        $display("test_reset: done");
    endtask

    task automatic test_entry();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        total++; if (state_o !== 3'(ST_EN_A)) begin bad++; $display("FAIL entry_en_a: got %0d want %0d", state_o, ST_EN_A); end
        hold(1'b1, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EN_AB)) begin bad++; $display("FAIL entry_en_ab: got %0d want %0d", state_o, ST_EN_AB); end
        hold(1'b0, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EN_B)) begin bad++; $display("FAIL entry_en_b: got %0d want %0d", state_o, ST_EN_B); end
        total++; if (n_enter !== 0) begin bad++; $display("FAIL entry_early: got %0d enter pulses want 0", n_enter); end
        hold(1'b0, 1'b0, 10);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL entry_idle: got %0d want %0d", state_o, ST_IDLE); end
        total++; if (n_enter !== 1) begin bad++; $display("FAIL entry_count: got %0d want 1", n_enter); end
        total++; if (enter_at < 6 || enter_at > 7) begin bad++; $display("FAIL entry_latency: got %0d want 6..7", enter_at); end
        total++; if (n_cnt_en !== 1 || n_cnt_up !== 1) begin bad++; $display("FAIL entry_cnt: got en=%0d up=%0d want 1/1", n_cnt_en, n_cnt_up); end
        total++; if (n_exit + n_err + n_excl + n_glue !== 0) begin bad++; $display("FAIL entry_other: got %0d stray want 0", n_exit + n_err + n_excl + n_glue); end
        $display("test_entry: enter_at=%0d", enter_at);
    endtask

    task automatic test_exit();
        clear_counts();
        hold(1'b0, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EX_B)) begin bad++; $display("FAIL exit_ex_b: got %0d want %0d", state_o, ST_EX_B); end
        hold(1'b1, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EX_AB)) begin bad++; $display("FAIL exit_ex_ab: got %0d want %0d", state_o, ST_EX_AB); end
        hold(1'b1, 1'b0, 10);
        total++; if (state_o !== 3'(ST_EX_A)) begin bad++; $display("FAIL exit_ex_a: got %0d want %0d", state_o, ST_EX_A); end
        hold(1'b0, 1'b0, 10);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL exit_idle: got %0d want %0d", state_o, ST_IDLE); end
        total++; if (n_exit !== 1) begin bad++; $display("FAIL exit_count: got %0d want 1", n_exit); end
        total++; if (exit_at < 6 || exit_at > 7) begin bad++; $display("FAIL exit_latency: got %0d want 6..7", exit_at); end
        total++; if (n_cnt_en !== 1 || n_cnt_up !== 0) begin bad++; $display("FAIL exit_cnt: got en=%0d up=%0d want 1/0", n_cnt_en, n_cnt_up); end
        total++; if (n_enter + n_err + n_excl + n_glue !== 0) begin bad++; $display("FAIL exit_other: got %0d stray want 0", n_enter + n_err + n_excl + n_glue); end
        $display("test_exit: exit_at=%0d", exit_at);
    endtask

    task automatic test_glitch();
        clear_counts();
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 10);
        total++; if (n_nonidle !== 0) begin bad++; $display("FAIL glitch_state: got %0d non-idle cycles want 0", n_nonidle); end
        total++; if (n_enter + n_exit + n_err + n_cnt_en !== 0) begin bad++; $display("FAIL glitch_pulses: got %0d want 0", n_enter + n_exit + n_err + n_cnt_en); end
        $display("test_glitch: done");
    endtask

    task automatic test_backout();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        total++; if (state_o !== 3'(ST_EN_A)) begin bad++; $display("FAIL backout_en_a: got %0d want %0d", state_o, ST_EN_A); end
        hold(1'b1, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EN_AB)) begin bad++; $display("FAIL backout_en_ab: got %0d want %0d", state_o, ST_EN_AB); end
        hold(1'b1, 1'b0, 10);
        total++; if (state_o !== 3'(ST_EN_A)) begin bad++; $display("FAIL backout_return: got %0d want %0d", state_o, ST_EN_A); end
        hold(1'b0, 1'b0, 10);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL backout_idle: got %0d want %0d", state_o, ST_IDLE); end
        total++; if (n_enter + n_exit + n_err !== 0) begin bad++; $display("FAIL backout_pulses: got %0d want 0", n_enter + n_exit + n_err); end
        $display("test_backout: done");
    endtask

    task automatic test_illegal();
        clear_counts();
        hold(1'b1, 1'b1, 10);
        total++; if (state_o !== 3'(ST_ERR)) begin bad++; $display("FAIL illegal_err: got %0d want %0d", state_o, ST_ERR); end
        total++; if (n_err !== 1) begin bad++; $display("FAIL illegal_pulse: got %0d want 1", n_err); end
        hold(1'b0, 1'b1, 10);
        total++; if (state_o !== 3'(ST_ERR)) begin bad++; $display("FAIL illegal_hold: got %0d want %0d", state_o, ST_ERR); end
        total++; if (n_err !== 1) begin bad++; $display("FAIL illegal_once: got %0d want 1", n_err); end
        hold(1'b0, 1'b0, 10);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL illegal_recover: got %0d want %0d", state_o, ST_IDLE); end
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        total++; if (n_enter !== 1 || n_exit !== 0 || n_err !== 1) begin bad++; $display("FAIL illegal_then_entry: got enter=%0d exit=%0d err=%0d want 1/0/1", n_enter, n_exit, n_err); end
        total++; if (n_excl !== 0) begin bad++; $display("FAIL illegal_exclusive: got %0d overlaps want 0", n_excl); end
        $display("test_illegal: done");
    endtask

    task automatic test_reset_mid();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        total++; if (state_o !== 3'(ST_EN_AB)) begin bad++; $display("FAIL rmid_setup: got %0d want %0d", state_o, ST_EN_AB); end
        rst_n = 1'b0;
        hold(1'b1, 1'b1, 2);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL rmid_idle: got %0d want %0d", state_o, ST_IDLE); end
        rst_n = 1'b1;
        hold(1'b1, 1'b1, 5);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL rmid_redebounce: got %0d want %0d", state_o, ST_IDLE); end
        hold(1'b1, 1'b1, 4);
        total++; if (state_o !== 3'(ST_ERR)) begin bad++; $display("FAIL rmid_err: got %0d want %0d", state_o, ST_ERR); end
        total++; if (n_err !== 1 || n_enter + n_exit !== 0) begin bad++; $display("FAIL rmid_pulses: got err=%0d car=%0d want 1/0", n_err, n_enter + n_exit); end
        hold(1'b0, 1'b0, 10);
        total++; if (state_o !== 3'(ST_IDLE)) begin bad++; $display("FAIL rmid_recover: got %0d want %0d", state_o, ST_IDLE); end
        $display("test_reset_mid: done");
    endtask

    task automatic test_back_to_back();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        // Raw 00 lasts one cycle so the filtered 10 lands the cycle after IDLE.
        hold(1'b0, 1'b0, 1);
        hold(1'b1, 1'b0, 10);
        total++; if (state_o !== 3'(ST_EN_A)) begin bad++; $display("FAIL b2b_second_start: got %0d want %0d", state_o, ST_EN_A); end
        total++; if (n_enter !== 1) begin bad++; $display("FAIL b2b_first: got %0d want 1", n_enter); end
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        total++; if (n_enter !== 2 || n_cnt_up !== 2) begin bad++; $display("FAIL b2b_count: got enter=%0d up=%0d want 2/2", n_enter, n_cnt_up); end
        total++; if (n_err + n_exit + n_glue !== 0) begin bad++; $display("FAIL b2b_other: got %0d stray want 0", n_err + n_exit + n_glue); end
        $display("test_back_to_back: done");
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_glitch();
        test_backout();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
